// File: rtl/cache_control_if.sv
// CPU/datapath/arbiter signal bundle for the two-way cache controller.
// state is a debug view of the controller FSM: 0 = IDLE, 1 = WRITEBACK, 2 = ALLOCATE.
interface cache_control_if;
    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic        hit;
    logic        comp0_out;
    logic        comp1_out;
    logic        vba0_out;
    logic        vba1_out;
    logic        dba0_out;
    logic        dba1_out;
    logic        lru_out;
    logic        va0_w;
    logic        va1_w;
    logic        ta0_w;
    logic        ta1_w;
    logic        da0_w;
    logic        da1_w;
    logic        dba0_w;
    logic        dba1_w;
    logic        la_w;
    logic        lru_in;
    logic        dba_in;
    logic        datamux_sel;
    logic        dawmux_sel;
    logic [1:0]  addrmux_sel;
    logic        arb_mem_read;
    logic        arb_mem_write;
    logic        arb_mem_resp;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [1:0]  state;

    // Handshakes: the CPU holds mem_read/mem_write until mem_resp; the controller
    // holds arb_mem_read/arb_mem_write until arb_mem_resp and never aborts them.
    modport master (
        output mem_read, mem_write, hit, comp0_out, comp1_out, vba0_out, vba1_out,
               dba0_out, dba1_out, lru_out, arb_mem_resp,
        input  mem_resp, va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w,
               la_w, lru_in, dba_in, datamux_sel, dawmux_sel, addrmux_sel,
               arb_mem_read, arb_mem_write, hit_count, miss_count, state
    );

    modport slave (
        input  mem_read, mem_write, hit, comp0_out, comp1_out, vba0_out, vba1_out,
               dba0_out, dba1_out, lru_out, arb_mem_resp,
        output mem_resp, va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w,
               la_w, lru_in, dba_in, datamux_sel, dawmux_sel, addrmux_sel,
               arb_mem_read, arb_mem_write, hit_count, miss_count, state
    );
endinterface

// File: rtl/cache_control.sv
// Two-way write-back cache controller: single-cycle hits, optional writeback of a
// dirty victim, then a line fill; saturating hit/miss counters.
module cache_control (
    input logic            clk,
    input logic            reset,
    cache_control_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   victim_q;
    logic   req;
    logic   hitway;
    logic   victim_dirty;
    logic   hit_event;
    logic   miss_event;

    assign req          = bus.mem_read | bus.mem_write;
    assign hitway       = bus.vba1_out & bus.comp1_out;
    assign victim_dirty = bus.lru_out ? (bus.vba1_out & bus.dba1_out)
                                      : (bus.vba0_out & bus.dba0_out);
    assign hit_event    = (state_q == IDLE) && req && bus.hit;
    assign miss_event   = (state_q == IDLE) && req && !bus.hit;
    assign bus.state    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            victim_q       <= 1'b0;
            bus.hit_count  <= 16'd0;
            bus.miss_count <= 16'd0;
        end else begin
            state_q <= state_d;
            if (miss_event) begin
                victim_q <= bus.lru_out;
            end
            if (hit_event && bus.hit_count != 16'hFFFF) begin
                bus.hit_count <= bus.hit_count + 16'd1;
            end
            if (miss_event && bus.miss_count != 16'hFFFF) begin
                bus.miss_count <= bus.miss_count + 16'd1;
            end
        end
    end

    // Outputs are gated by reset so an in-flight arbiter request drops without a clock edge.
    always_comb begin
        state_d          = state_q;
        bus.mem_resp     = 1'b0;
        bus.va0_w        = 1'b0;
        bus.va1_w        = 1'b0;
        bus.ta0_w        = 1'b0;
        bus.ta1_w        = 1'b0;
        bus.da0_w        = 1'b0;
        bus.da1_w        = 1'b0;
        bus.dba0_w       = 1'b0;
        bus.dba1_w       = 1'b0;
        bus.la_w         = 1'b0;
        bus.lru_in       = 1'b0;
        bus.dba_in       = 1'b0;
        bus.datamux_sel  = 1'b0;
        bus.dawmux_sel   = 1'b0;
        bus.addrmux_sel  = 2'd0;
        bus.arb_mem_read = 1'b0;
        bus.arb_mem_write = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (req && bus.hit) begin
                        bus.mem_resp    = 1'b1;
                        bus.datamux_sel = hitway;
                        bus.la_w        = 1'b1;
                        bus.lru_in      = ~hitway;
                        if (bus.mem_write) begin
                            bus.dawmux_sel = 1'b0;
                            bus.da0_w      = ~hitway;
                            bus.da1_w      = hitway;
                            bus.dba0_w     = ~hitway;
                            bus.dba1_w     = hitway;
                            bus.dba_in     = 1'b1;
                        end
                    end else if (req) begin
                        state_d = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    bus.arb_mem_write = 1'b1;
                    bus.datamux_sel   = victim_q;
                    bus.addrmux_sel   = victim_q ? 2'd2 : 2'd1;
                    if (bus.arb_mem_resp) begin
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    bus.arb_mem_read = 1'b1;
                    bus.addrmux_sel  = 2'd0;
                    if (bus.arb_mem_resp) begin
                        // Fill the victim way with a clean, valid line.
                        bus.dawmux_sel = 1'b1;
                        bus.da0_w      = ~victim_q;
                        bus.da1_w      = victim_q;
                        bus.ta0_w      = ~victim_q;
                        bus.ta1_w      = victim_q;
                        bus.va0_w      = ~victim_q;
                        bus.va1_w      = victim_q;
                        bus.dba0_w     = ~victim_q;
                        bus.dba1_w     = victim_q;
                        bus.dba_in     = 1'b0;
                        state_d        = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed scenarios, random traffic against a
// behavioural model, and hit-counter saturation.
module tb_cache_control;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cache_control_if bus ();

    cache_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_resp;
        logic       va0_w;
        logic       va1_w;
        logic       ta0_w;
        logic       ta1_w;
        logic       da0_w;
        logic       da1_w;
        logic       dba0_w;
        logic       dba1_w;
        logic       la_w;
        logic       lru_in;
        logic       dba_in;
        logic       datamux_sel;
        logic       dawmux_sel;
        logic [1:0] addrmux_sel;
        logic       arb_mem_read;
        logic       arb_mem_write;
    } outs_t;

    // Model: what the controller is doing (0 idle, 1 writing victim back, 2 filling),
    // which way is being replaced, and the event tallies.
    int   m_phase;
    logic m_victim;
    int   m_hits;
    int   m_misses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.mem_resp      = bus.mem_resp;
        o.va0_w         = bus.va0_w;
        o.va1_w         = bus.va1_w;
        o.ta0_w         = bus.ta0_w;
        o.ta1_w         = bus.ta1_w;
        o.da0_w         = bus.da0_w;
        o.da1_w         = bus.da1_w;
        o.dba0_w        = bus.dba0_w;
        o.dba1_w        = bus.dba1_w;
        o.la_w          = bus.la_w;
        o.lru_in        = bus.lru_in;
        o.dba_in        = bus.dba_in;
        o.datamux_sel   = bus.datamux_sel;
        o.dawmux_sel    = bus.dawmux_sel;
        o.addrmux_sel   = bus.addrmux_sel;
        o.arb_mem_read  = bus.arb_mem_read;
        o.arb_mem_write = bus.arb_mem_write;
        return o;
    endfunction

    function automatic outs_t exp_outs();
        outs_t o;
        logic  req;
        logic  way;
        o   = '0;
        req = bus.mem_read | bus.mem_write;
        way = bus.vba1_out & bus.comp1_out;
        if (reset) return o;
        if (m_phase == 0 && req && bus.hit) begin
            o.mem_resp    = 1'b1;
            o.datamux_sel = way;
            o.la_w        = 1'b1;
            o.lru_in      = !way;
            if (bus.mem_write) begin
                if (way) begin o.da1_w = 1'b1; o.dba1_w = 1'b1; end
                else     begin o.da0_w = 1'b1; o.dba0_w = 1'b1; end
                o.dba_in = 1'b1;
            end
        end else if (m_phase == 1) begin
            o.arb_mem_write = 1'b1;
            o.datamux_sel   = m_victim;
            o.addrmux_sel   = m_victim ? 2'd2 : 2'd1;
        end else if (m_phase == 2) begin
            o.arb_mem_read = 1'b1;
            if (bus.arb_mem_resp) begin
                o.dawmux_sel = 1'b1;
                if (m_victim) {o.da1_w, o.ta1_w, o.va1_w, o.dba1_w} = 4'hF;
                else          {o.da0_w, o.ta0_w, o.va0_w, o.dba0_w} = 4'hF;
            end
        end
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  <= 0;
            m_victim <= 1'b0;
            m_hits   <= 0;
            m_misses <= 0;
        end else begin
            case (m_phase)
                0: if (bus.mem_read | bus.mem_write) begin
                    if (bus.hit) begin
                        m_hits <= (m_hits < 65535) ? m_hits + 1 : 65535;
                    end else begin
                        m_misses <= (m_misses < 65535) ? m_misses + 1 : 65535;
                        m_victim <= bus.lru_out;
                        if (bus.lru_out ? (bus.vba1_out && bus.dba1_out)
                                        : (bus.vba0_out && bus.dba0_out))
                            m_phase <= 1;
                        else
                            m_phase <= 2;
                    end
                end
                1: if (bus.arb_mem_resp) m_phase <= 2;
                default: if (bus.arb_mem_resp) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("outputs", 32'(dut_outs()), 32'(exp_outs()));
        check("state", 32'(bus.state), 32'(m_phase));
        check("hit_count", 32'(bus.hit_count), 32'(m_hits));
        check("miss_count", 32'(bus.miss_count), 32'(m_misses));
        if (bus.arb_mem_read && bus.arb_mem_write) begin
            check("arb_exclusive", 32'd1, 32'd0);
        end
    end

    task automatic clear_inputs();
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.hit          = 1'b0;
        bus.comp0_out    = 1'b0;
        bus.comp1_out    = 1'b0;
        bus.vba0_out     = 1'b0;
        bus.vba1_out     = 1'b0;
        bus.dba0_out     = 1'b0;
        bus.dba1_out     = 1'b0;
        bus.lru_out      = 1'b0;
        bus.arb_mem_resp = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        reset = 1'b1;
        #3;
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_outs", 32'(dut_outs()), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Read hit on way 1.
        bus.mem_read = 1'b1; bus.hit = 1'b1; bus.vba1_out = 1'b1; bus.comp1_out = 1'b1;
        #2;
        check("rd_hit_resp", 32'(bus.mem_resp), 32'd1);
        check("rd_hit_datamux", 32'(bus.datamux_sel), 32'd1);
        check("rd_hit_la_w", 32'(bus.la_w), 32'd1);
        check("rd_hit_lru_in", 32'(bus.lru_in), 32'd0);
        step();
        clear_inputs();
        check("rd_hit_count", 32'(bus.hit_count), 32'd1);
        step();

        // Write hit on way 0.
        bus.mem_write = 1'b1; bus.hit = 1'b1; bus.vba0_out = 1'b1; bus.comp0_out = 1'b1;
        #2;
        check("wr_hit_resp", 32'(bus.mem_resp), 32'd1);
        check("wr_hit_da0_w", 32'(bus.da0_w), 32'd1);
        check("wr_hit_dba0_w", 32'(bus.dba0_w), 32'd1);
        check("wr_hit_dba_in", 32'(bus.dba_in), 32'd1);
        check("wr_hit_dawmux", 32'(bus.dawmux_sel), 32'd0);
        check("wr_hit_da1_w", 32'(bus.da1_w), 32'd0);
        step();
        clear_inputs();
        step();

        // Clean miss, victim way 1.
        bus.mem_read = 1'b1; bus.lru_out = 1'b1; bus.vba1_out = 1'b1;
        #2;
        check("clean_miss_resp", 32'(bus.mem_resp), 32'd0);
        step();
        check("clean_alloc_state", 32'(bus.state), 32'd2);
        check("clean_arb_read", 32'(bus.arb_mem_read), 32'd1);
        check("clean_addrmux", 32'(bus.addrmux_sel), 32'd0);
        check("clean_miss_count", 32'(bus.miss_count), 32'd1);
        step();
        step();
        bus.arb_mem_resp = 1'b1;
        #2;
        check("clean_fill_we", 32'({bus.da1_w, bus.ta1_w, bus.va1_w, bus.dba1_w}), 32'hF);
        check("clean_fill_dba_in", 32'(bus.dba_in), 32'd0);
        check("clean_fill_dawmux", 32'(bus.dawmux_sel), 32'd1);
        step();
        bus.arb_mem_resp = 1'b0; bus.hit = 1'b1; bus.comp1_out = 1'b1;
        #2;
        check("clean_retry_resp", 32'(bus.mem_resp), 32'd1);
        step();
        clear_inputs();
        step();

        // Dirty miss, victim way 0.
        bus.mem_write = 1'b1; bus.vba0_out = 1'b1; bus.dba0_out = 1'b1;
        step();
        check("dirty_wb_state", 32'(bus.state), 32'd1);
        check("dirty_arb_write", 32'(bus.arb_mem_write), 32'd1);
        check("dirty_addrmux", 32'(bus.addrmux_sel), 32'd1);
        check("dirty_datamux", 32'(bus.datamux_sel), 32'd0);
        step();
        bus.arb_mem_resp = 1'b1;
        step();
        bus.arb_mem_resp = 1'b0;
        check("dirty_alloc_state", 32'(bus.state), 32'd2);
        step();
        bus.arb_mem_resp = 1'b1;
        #2;
        check("dirty_fill_we", 32'({bus.da0_w, bus.ta0_w, bus.va0_w, bus.dba0_w}), 32'hF);
        step();
        // Request withdrawn while filling: no response afterwards.
        clear_inputs();
        #2;
        check("withdrawn_resp", 32'(bus.mem_resp), 32'd0);
        step();

        // Reset between clock edges during WRITEBACK.
        bus.mem_read = 1'b1; bus.lru_out = 1'b1; bus.vba1_out = 1'b1; bus.dba1_out = 1'b1;
        step();
        check("rst_pre_arb_write", 32'(bus.arb_mem_write), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_arb_write", 32'(bus.arb_mem_write), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_counts", 32'({bus.hit_count, bus.miss_count}), 32'd0);
        clear_inputs();
        step();
        reset = 1'b0;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.mem_read     = 1'($urandom_range(0, 1));
            bus.mem_write    = ($urandom_range(0, 3) == 0);
            bus.hit          = 1'($urandom_range(0, 1));
            bus.comp0_out    = 1'($urandom_range(0, 1));
            bus.comp1_out    = 1'($urandom_range(0, 1));
            bus.vba0_out     = 1'($urandom_range(0, 1));
            bus.vba1_out     = 1'($urandom_range(0, 1));
            bus.dba0_out     = 1'($urandom_range(0, 1));
            bus.dba1_out     = 1'($urandom_range(0, 1));
            bus.lru_out      = 1'($urandom_range(0, 1));
            bus.arb_mem_resp = ($urandom_range(0, 3) == 0);
            step();
        end

        // Hit counter saturation.
        clear_inputs();
        apply_reset();
        bus.mem_read = 1'b1; bus.hit = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        check("sat_hit_count", 32'(bus.hit_count), 32'h0000FFFF);
        step();
        step();
        check("sat_hold", 32'(bus.hit_count), 32'h0000FFFF);
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
Parameters: none.
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read, mem_write  in  1 each  CPU request strobes, held until mem_resp.
- mem_resp  out  1  request complete.
- hit, comp0_out, comp1_out, vba0_out, vba1_out, dba0_out, dba1_out, lru_out  in  1 each  datapath status for the indexed set.
- va0_w, va1_w, ta0_w, ta1_w, da0_w, da1_w, dba0_w, dba1_w, la_w  out  1 each  array write enables.
- lru_in, dba_in, datamux_sel, dawmux_sel  out  1 each  datapath data/select controls.
- addrmux_sel  out  2  0 = CPU address, 1 = way-0 tag address, 2 = way-1 tag address.
- arb_mem_read, arb_mem_write  out  1 each  line fill / writeback request to arbiter.
- arb_mem_resp  in  1  arbiter transaction done.
- hit_count, miss_count  out  16 each  performance counters.

Function
REQ-002 States SHALL be IDLE, WRITEBACK and ALLOCATE; all outputs SHALL be combinational from state and inputs, except the counters and victim register.
REQ-003 Every output not explicitly asserted in a state SHALL be 0.
REQ-004 IDLE with no request: all outputs 0.
REQ-005 Request selection: req = mem_read | mem_write; a write SHALL occur when mem_write = 1, including when both strobes are high.
REQ-006 Hit way: hitway = vba1_out & comp1_out.
REQ-007 IDLE with req and hit = 1 SHALL, in the same cycle:
- assert mem_resp;
- drive datamux_sel = hitway;
- assert la_w with lru_in = ~hitway;
- remain in IDLE (hit latency: 1 cycle).
REQ-008 A write hit SHALL additionally drive dawmux_sel = 0, assert da<hitway>_w and dba<hitway>_w, and drive dba_in = 1.
REQ-009 IDLE with req and hit = 0 SHALL:
- latch victim = lru_out;
- go to WRITEBACK when the victim way is both valid and dirty, otherwise go to ALLOCATE;
- not assert mem_resp.
REQ-010 WRITEBACK SHALL drive:
- arb_mem_write = 1;
- datamux_sel = victim;
- addrmux_sel = victim ? 2 : 1.
It SHALL go to ALLOCATE on arb_mem_resp.
REQ-011 ALLOCATE SHALL drive arb_mem_read = 1 and addrmux_sel = 0.
REQ-012 On arb_mem_resp in ALLOCATE, the block SHALL:
- drive dawmux_sel = 1;
- assert da<victim>_w, ta<victim>_w, va<victim>_w and dba<victim>_w with dba_in = 0;
- go to IDLE.
The retried access then hits in IDLE on the following cycle.
REQ-013 arb_mem_read and arb_mem_write SHALL never be asserted together.
REQ-014 Each arbiter request SHALL stay asserted until arb_mem_resp, even if the CPU strobes drop; an arbiter transaction is never aborted.
REQ-015 A miss that finds the CPU request withdrawn on return to IDLE SHALL complete silently, with no mem_resp.
REQ-016 hit_count SHALL increment on every IDLE hit-response cycle.
REQ-017 miss_count SHALL increment on every IDLE miss-detection cycle.
REQ-018 Both counters SHALL saturate at 16'hFFFF.
REQ-019 The victim register SHALL be written only on miss detection in IDLE.

Reset
REQ-020 While reset = 1, the block SHALL asynchronously force:
- state = IDLE;
- victim = 0;
- hit_count = 0 and miss_count = 0;
- all outputs to 0.
REQ-021 Reset asserted during WRITEBACK or ALLOCATE SHALL drop arb_mem_read and arb_mem_write within the same cycle, without waiting for a clock edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read hit, way 1 valid and tag-matched: mem_read = 1 -> same-cycle mem_resp = 1, datamux_sel = 1, la_w = 1, lru_in = 0, hit_count = 1.
- Write hit, way 0: mem_write = 1 -> mem_resp = 1, da0_w = 1, dba0_w = 1, dba_in = 1, dawmux_sel = 0.
- Clean miss, lru_out = 1, way 1 not dirty: -> ALLOCATE, arb_mem_read = 1, addrmux_sel = 0. arb_mem_resp after 3 cycles -> da1_w = ta1_w = va1_w = dba1_w = 1, dba_in = 0. Next cycle mem_resp = 1; miss_count = 1.
- Dirty miss, lru_out = 0, way 0 valid and dirty: -> WRITEBACK, arb_mem_write = 1, addrmux_sel = 1, datamux_sel = 0. arb_mem_resp -> ALLOCATE; fill completes as above for way 0.
- Reset mid-WRITEBACK: reset pulsed between clock edges -> arb_mem_write = 0 immediately, state IDLE, counters = 0.
- Saturation: force 65536 hits -> hit_count holds at 16'hFFFF.
